// File: rtl/param_write_arbiter.sv
// rtl/param_write_arbiter.sv - shares the patch parameter RAM write port between the MIDI sysex FIFO and the host bus
// Each accepted request becomes a registered SETUP/STROBE write with one-hot bank selects.
module param_write_arbiter #(
   parameter int FIFO_AW     = 2,
   parameter int MIDI_STREAK = 4
) (
   input  logic               CLOCK_25,
   input  logic               iRST_N,
   input  logic               midi_wr,
   input  logic [2:0]         midi_bank,
   input  logic [6:0]         midi_adr,
   input  logic [7:0]         midi_data,
   input  logic               host_req,
   input  logic [2:0]         host_bank,
   input  logic [6:0]         host_adr,
   input  logic [7:0]         host_data,
   output logic               host_ack,
   output logic               write,
   output logic [6:0]         adr,
   output logic [7:0]         data,
   output logic               env_sel,
   output logic               osc_sel,
   output logic               m1_sel,
   output logic               m2_sel,
   output logic               com_sel,
   output logic [FIFO_AW:0]   fifo_level,
   output logic               midi_overflow,
   output logic               bank_err,
   output logic               busy
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam int SW    = $clog2(MIDI_STREAK + 1);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE} state_t;

   state_t              state_q;
   logic                owner_host_q;
   logic                bank_ok_q;
   logic [SW-1:0]       streak_q, streak_d;
   logic [17:0]         mem_q [DEPTH];
   logic [FIFO_AW-1:0]  wptr_q, rptr_q;
   logic [FIFO_AW:0]    level_q, level_d;
   logic                overflow_q;
   logic [6:0]          adr_q;
   logic [7:0]          data_q;
   logic [4:0]          sel_q;
   logic                write_q, ack_q, busy_q, bank_err_q;

   logic                fifo_empty, fifo_full, push_ok;
   logic                decide, host_elig, grant_host, grant_midi, grant;
   logic [17:0]         head;
   logic [2:0]          win_bank;
   logic [6:0]          win_adr;
   logic [7:0]          win_data;
   logic [4:0]          win_sel;
   logic                win_ok;

   assign fifo_empty = (level_q == '0);
   assign fifo_full  = (level_q == (FIFO_AW+1)'(DEPTH));
   assign head       = mem_q[rptr_q];

   // The host is deaf during the STROBE of its own write so a held host_req is not re-granted.
   assign decide     = (state_q == IDLE) || (state_q == STROBE);
   assign host_elig  = host_req && !((state_q == STROBE) && owner_host_q);
   assign grant_host = decide && host_elig && (fifo_empty || (streak_q == SW'(MIDI_STREAK)));
   assign grant_midi = decide && !fifo_empty && !grant_host;
   assign grant      = grant_host || grant_midi;

   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign push_ok    = midi_wr && (!fifo_full || grant_midi);

   always_comb begin
      level_d = level_q;
      if (push_ok && !grant_midi) begin
         level_d = level_q + 1'b1;
      end else if (!push_ok && grant_midi) begin
         level_d = level_q - 1'b1;
      end
   end

   always_comb begin
      streak_d = streak_q;
      if (grant_host || !host_req) begin
         streak_d = '0;
      end else if (grant_midi && (streak_q != SW'(MIDI_STREAK))) begin
         streak_d = streak_q + 1'b1;
      end
   end

   always_comb begin
      win_bank = grant_host ? host_bank : head[17:15];
      win_adr  = grant_host ? host_adr  : head[14:8];
      win_data = grant_host ? host_data : head[7:0];
      win_ok   = (win_bank <= 3'd4);
      win_sel  = 5'b00000;
      case (win_bank)
         3'd0:    win_sel = 5'b00001;
         3'd1:    win_sel = 5'b00010;
         3'd2:    win_sel = 5'b00100;
         3'd3:    win_sel = 5'b01000;
         3'd4:    win_sel = 5'b10000;
         default: win_sel = 5'b00000;
      endcase
   end

   always_ff @(posedge CLOCK_25) begin
      if (push_ok) begin
         mem_q[wptr_q] <= {midi_bank, midi_adr, midi_data};
      end
   end

   always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
      if (!iRST_N) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         level_q <= level_d;
         if (push_ok) begin
            wptr_q <= wptr_q + 1'b1;
         end
         if (grant_midi) begin
            rptr_q <= rptr_q + 1'b1;
         end
         if (midi_wr && !push_ok) begin
            overflow_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q      <= IDLE;
         owner_host_q <= 1'b0;
         bank_ok_q    <= 1'b0;
         streak_q     <= '0;
         adr_q        <= '0;
         data_q       <= '0;
         sel_q        <= '0;
         write_q      <= 1'b0;
         ack_q        <= 1'b0;
         busy_q       <= 1'b0;
         bank_err_q   <= 1'b0;
      end else begin
         streak_q <= streak_d;
         write_q  <= 1'b0;
         ack_q    <= 1'b0;
         if (grant) begin
            state_q      <= SETUP;
            owner_host_q <= grant_host;
            bank_ok_q    <= win_ok;
            adr_q        <= win_adr;
            data_q       <= win_data;
            sel_q        <= win_sel;
            busy_q       <= 1'b1;
            if (!win_ok) begin
               bank_err_q <= 1'b1;
            end
         end else begin
            case (state_q)
               SETUP: begin
                  state_q <= STROBE;
                  write_q <= bank_ok_q;
                  ack_q   <= owner_host_q;
               end
               STROBE: begin
                  state_q <= IDLE;
                  sel_q   <= '0;
                  busy_q  <= 1'b0;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign host_ack      = ack_q;
   assign write         = write_q;
   assign adr           = adr_q;
   assign data          = data_q;
   assign env_sel       = sel_q[0];
   assign osc_sel       = sel_q[1];
   assign m1_sel        = sel_q[2];
   assign m2_sel        = sel_q[3];
   assign com_sel       = sel_q[4];
   assign fifo_level    = level_q;
   assign midi_overflow = overflow_q;
   assign bank_err      = bank_err_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_param_write_arbiter.sv
// tb/tb_param_write_arbiter.sv - directed self-checking bench for param_write_arbiter
// Inputs change and outputs are sampled on the falling edge; cycle n is the period ending at a rising edge.
module tb_param_write_arbiter;
   logic       CLOCK_25 = 1'b0;
   logic       iRST_N = 1'b0;
   logic       midi_wr = 1'b0;
   logic [2:0] midi_bank = '0;
   logic [6:0] midi_adr = '0;
   logic [7:0] midi_data = '0;
   logic       host_req = 1'b0;
   logic [2:0] host_bank = '0;
   logic [6:0] host_adr = '0;
   logic [7:0] host_data = '0;
   logic       host_ack, write, env_sel, osc_sel, m1_sel, m2_sel, com_sel;
   logic       midi_overflow, bank_err, busy;
   logic [6:0] adr;
   logic [7:0] data;
   logic [2:0] fifo_level;
   logic [4:0] sels;

   int n_cmp = 0;
   int n_fail = 0;

   assign sels = {com_sel, m2_sel, m1_sel, osc_sel, env_sel};

   param_write_arbiter #(.FIFO_AW(2), .MIDI_STREAK(4)) dut (
      .CLOCK_25(CLOCK_25), .iRST_N(iRST_N),
      .midi_wr(midi_wr), .midi_bank(midi_bank), .midi_adr(midi_adr), .midi_data(midi_data),
      .host_req(host_req), .host_bank(host_bank), .host_adr(host_adr), .host_data(host_data),
      .host_ack(host_ack), .write(write), .adr(adr), .data(data),
      .env_sel(env_sel), .osc_sel(osc_sel), .m1_sel(m1_sel), .m2_sel(m2_sel), .com_sel(com_sel),
      .fifo_level(fifo_level), .midi_overflow(midi_overflow), .bank_err(bank_err), .busy(busy)
   );

   always #5 CLOCK_25 = ~CLOCK_25;

   task automatic test_reset;
      repeat (2) @(negedge CLOCK_25);
      n_cmp++;
      if ({write, host_ack, sels, busy, midi_overflow, bank_err} !== 10'b0) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 0", {write, host_ack, sels, busy, midi_overflow, bank_err});
      end
      n_cmp++;
      if ({adr, data, fifo_level} !== 18'b0) begin
         n_fail++; $display("FAIL reset_values: got %h expected 0", {adr, data, fifo_level});
      end
      iRST_N = 1'b1;
      repeat (3) @(negedge CLOCK_25);
      n_cmp++;
      if ({busy, write} !== 2'b00) begin
         n_fail++; $display("FAIL reset_idle: got %b expected 00", {busy, write});
      end
   endtask

   task automatic test_single_midi;
      @(negedge CLOCK_25);
      midi_wr = 1'b1; midi_bank = 3'd1; midi_adr = 7'h12; midi_data = 8'h55;
      @(negedge CLOCK_25);
      midi_wr = 1'b0;
      n_cmp++;
      if ({write, sels, fifo_level} !== {1'b0, 5'b00000, 3'd1}) begin
         n_fail++; $display("FAIL midi_n1: got %b expected 0_00000_001", {write, sels, fifo_level});
      end
      @(negedge CLOCK_25);
      n_cmp++;
      if ({write, sels, busy, adr, data, fifo_level} !== {1'b0, 5'b00010, 1'b1, 7'h12, 8'h55, 3'd0}) begin
         n_fail++; $display("FAIL midi_setup: got w=%b sel=%b busy=%b adr=%h data=%h lvl=%0d expected 0 00010 1 12 55 0", write, sels, busy, adr, data, fifo_level);
      end
      @(negedge CLOCK_25);
      n_cmp++;
      if ({write, host_ack, sels, adr, data} !== {1'b1, 1'b0, 5'b00010, 7'h12, 8'h55}) begin
         n_fail++; $display("FAIL midi_strobe: got w=%b ack=%b sel=%b adr=%h data=%h expected 1 0 00010 12 55", write, host_ack, sels, adr, data);
      end
      @(negedge CLOCK_25);
      n_cmp++;
      if ({write, sels, busy, adr, data, fifo_level} !== {1'b0, 5'b00000, 1'b0, 7'h12, 8'h55, 3'd0}) begin
         n_fail++; $display("FAIL midi_after: got w=%b sel=%b busy=%b adr=%h data=%h lvl=%0d expected 0 00000 0 12 55 0", write, sels, busy, adr, data, fifo_level);
      end
   endtask

   task automatic test_host_latency;
      @(negedge CLOCK_25);
      host_req = 1'b1; host_bank = 3'd2; host_adr = 7'h21; host_data = 8'h9A;
      @(negedge CLOCK_25);
      n_cmp++;
      if ({write, host_ack, sels, busy} !== {1'b0, 1'b0, 5'b00100, 1'b1}) begin
         n_fail++; $display("FAIL host_setup: got %b expected 0_0_00100_1", {write, host_ack, sels, busy});
      end
      @(negedge CLOCK_25);
      n_cmp++;
      if ({write, host_ack, sels, adr, data} !== {1'b1, 1'b1, 5'b00100, 7'h21, 8'h9A}) begin
         n_fail++; $display("FAIL host_strobe: got w=%b ack=%b sel=%b adr=%h data=%h expected 1 1 00100 21 9a", write, host_ack, sels, adr, data);
      end
      @(posedge CLOCK_25);
      #1 host_req = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLOCK_25);
         n_cmp++;
         if ({write, host_ack, sels, busy} !== 8'b0) begin
            n_fail++; $display("FAIL host_no_regrant[%0d]: got %b expected 0", k, {write, host_ack, sels, busy});
         end
      end
   endtask

   task automatic test_bank_dump;
      fork
         begin
            for (int i = 0; i < 64; i++) begin
               @(negedge CLOCK_25);
               midi_wr = 1'b1; midi_bank = 3'd0; midi_adr = 7'(i); midi_data = 8'(i * 3 + 7);
               @(negedge CLOCK_25);
               midi_wr = 1'b0;
               repeat (2) @(negedge CLOCK_25);
            end
         end
         begin
            int cnt;
            cnt = 0;
            for (int c = 0; c < 290 && cnt < 64; c++) begin
               @(negedge CLOCK_25);
               if (write) begin
                  n_cmp++;
                  if ({sels, adr, data} !== {5'b00001, 7'(cnt), 8'(cnt * 3 + 7)}) begin
                     n_fail++; $display("FAIL dump_write[%0d]: got sel=%b adr=%h data=%h expected 00001 %h %h", cnt, sels, adr, data, 7'(cnt), 8'(cnt * 3 + 7));
                  end
                  cnt++;
               end
            end
            n_cmp++;
            if (cnt !== 64) begin
               n_fail++; $display("FAIL dump_count: got %0d expected 64", cnt);
            end
         end
      join
      repeat (4) @(negedge CLOCK_25);
      n_cmp++;
      if ({midi_overflow, fifo_level} !== 4'b0) begin
         n_fail++; $display("FAIL dump_end: got ovf=%b lvl=%0d expected 0 0", midi_overflow, fifo_level);
      end
   endtask

   task automatic test_overflow;
      logic [12:0] got[$];
      logic [12:0] exp_w [10] = '{13'h0830, 13'h0831, 13'h0832, 13'h0833, 13'h0834,
                                  13'h0835, 13'h0836, 13'h0837, 13'h0839, 13'h083B};
      fork
         begin
            for (int i = 0; i < 12; i++) begin
               @(negedge CLOCK_25);
               if (i == 8) begin
                  n_cmp++;
                  if ({midi_overflow, fifo_level} !== {1'b0, 3'd4}) begin
                     n_fail++; $display("FAIL ovf_full: got ovf=%b lvl=%0d expected 0 4", midi_overflow, fifo_level);
                  end
               end
               if (i == 9) begin
                  n_cmp++;
                  if ({midi_overflow, fifo_level} !== {1'b1, 3'd4}) begin
                     n_fail++; $display("FAIL ovf_drop: got ovf=%b lvl=%0d expected 1 4", midi_overflow, fifo_level);
                  end
               end
               midi_wr = 1'b1; midi_bank = 3'd3; midi_adr = 7'(i); midi_data = 8'(8'h30 + i);
            end
            @(negedge CLOCK_25);
            midi_wr = 1'b0;
         end
         begin
            for (int c = 0; c < 40; c++) begin
               @(negedge CLOCK_25);
               if (write) got.push_back({sels, data});
            end
         end
      join
      n_cmp++;
      if (got.size() !== 10) begin
         n_fail++; $display("FAIL ovf_count: got %0d expected 10", got.size());
      end
      for (int k = 0; k < 10 && k < got.size(); k++) begin
         n_cmp++;
         if (got[k] !== exp_w[k]) begin
            n_fail++; $display("FAIL ovf_write[%0d]: got %h expected %h", k, got[k], exp_w[k]);
         end
      end
      n_cmp++;
      if ({midi_overflow, fifo_level} !== {1'b1, 3'd0}) begin
         n_fail++; $display("FAIL ovf_end: got ovf=%b lvl=%0d expected 1 0", midi_overflow, fifo_level);
      end
   endtask

   task automatic test_starvation;
      logic [13:0] pul[$];
      logic [13:0] exp_p [6] = '{14'h0482, 14'h0483, 14'h0484, 14'h0485, 14'h30C3, 14'h0486};
      int acks;
      acks = 0;
      fork
         begin
            int k;
            k = 0;
            for (int c = 0; c < 32; c++) begin
               @(negedge CLOCK_25);
               if (k < 16 && c == ((k < 3) ? k : 2 * k - 2)) begin
                  midi_wr = 1'b1; midi_bank = 3'd2; midi_adr = 7'(k); midi_data = 8'(8'h80 + k);
                  k++;
               end else begin
                  midi_wr = 1'b0;
               end
            end
            midi_wr = 1'b0;
         end
         begin
            int seen;
            seen = 0;
            for (int c = 0; c < 30 && seen < 2; c++) begin
               @(negedge CLOCK_25);
               if (write) seen++;
            end
            host_req = 1'b1; host_bank = 3'd4; host_adr = 7'h7F; host_data = 8'hC3;
            for (int c = 0; c < 40 && pul.size() < 6; c++) begin
               @(negedge CLOCK_25);
               if (host_ack) acks++;
               if (write) pul.push_back({host_ack, sels, data});
               if (host_ack) begin
                  @(posedge CLOCK_25);
                  #1 host_req = 1'b0;
               end
            end
         end
      join
      n_cmp++;
      if (pul.size() !== 6) begin
         n_fail++; $display("FAIL starve_count: got %0d expected 6", pul.size());
      end
      for (int k = 0; k < 6 && k < pul.size(); k++) begin
         n_cmp++;
         if (pul[k] !== exp_p[k]) begin
            n_fail++; $display("FAIL starve_write[%0d]: got %h expected %h", k, pul[k], exp_p[k]);
         end
      end
      n_cmp++;
      if (acks !== 1) begin
         n_fail++; $display("FAIL starve_ack_pulses: got %0d expected 1", acks);
      end
      repeat (20) @(negedge CLOCK_25);
   endtask

   task automatic test_invalid_bank;
      @(negedge CLOCK_25);
      n_cmp++;
      if (bank_err !== 1'b0) begin
         n_fail++; $display("FAIL badbank_pre: got %b expected 0", bank_err);
      end
      host_req = 1'b1; host_bank = 3'd6; host_adr = 7'h05; host_data = 8'hEE;
      @(negedge CLOCK_25);
      n_cmp++;
      if ({write, host_ack, sels, busy} !== {1'b0, 1'b0, 5'b0, 1'b1}) begin
         n_fail++; $display("FAIL badbank_setup: got %b expected 0_0_00000_1", {write, host_ack, sels, busy});
      end
      @(negedge CLOCK_25);
      n_cmp++;
      if ({write, host_ack, sels, busy, bank_err} !== {1'b0, 1'b1, 5'b0, 1'b1, 1'b1}) begin
         n_fail++; $display("FAIL badbank_strobe: got %b expected 0_1_00000_1_1", {write, host_ack, sels, busy, bank_err});
      end
      @(posedge CLOCK_25);
      #1 host_req = 1'b0;
      @(negedge CLOCK_25);
      n_cmp++;
      if ({write, host_ack, busy, bank_err} !== 4'b0001) begin
         n_fail++; $display("FAIL badbank_after: got %b expected 0001", {write, host_ack, busy, bank_err});
      end
   endtask

   task automatic test_reset_in_setup;
      int bad;
      repeat (2) @(negedge CLOCK_25);
      host_req = 1'b1; host_bank = 3'd1; host_adr = 7'h44; host_data = 8'h11;
      midi_wr = 1'b1; midi_bank = 3'd0; midi_adr = 7'h01; midi_data = 8'h02;
      @(negedge CLOCK_25);
      midi_wr = 1'b0;
      n_cmp++;
      if ({busy, sels, fifo_level} !== {1'b1, 5'b00010, 3'd1}) begin
         n_fail++; $display("FAIL rst_pre: got %b expected 1_00010_001", {busy, sels, fifo_level});
      end
      #2 iRST_N = 1'b0;
      #1;
      n_cmp++;
      if ({write, host_ack, sels, busy, fifo_level} !== 11'b0) begin
         n_fail++; $display("FAIL rst_async: got %b expected 0", {write, host_ack, sels, busy, fifo_level});
      end
      n_cmp++;
      if ({adr, data, midi_overflow, bank_err} !== 17'b0) begin
         n_fail++; $display("FAIL rst_regs: got %h expected 0", {adr, data, midi_overflow, bank_err});
      end
      host_req = 1'b0;
      @(negedge CLOCK_25);
      iRST_N = 1'b1;
      bad = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge CLOCK_25);
         if (host_ack || write || busy) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin
         n_fail++; $display("FAIL rst_no_resume: got %0d active cycles expected 0", bad);
      end
   endtask

   initial begin
      test_reset;
      test_single_midi;
      repeat (3) @(negedge CLOCK_25);
      test_host_latency;
      repeat (3) @(negedge CLOCK_25);
      test_bank_dump;
      test_overflow;
      repeat (3) @(negedge CLOCK_25);
      test_starvation;
      test_invalid_bank;
      test_reset_in_setup;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
